bp_me_cache_dma_to_block_mem: RTL and testbench

- Sits directly downstream of the L2 cache slice's DMA side.
- Consumes the slice's dram-format mem_cmd header plus its dword-wide write-data stream, and drives a single-beat, block-wide memory port.
- Returns a mem_resp header, plus a dword-wide read-data stream for reads.
- Half-duplex: exactly one transaction is in flight at a time, and one block buffer is shared by the read and write paths.

---
 rtl/bp_me_pkg.sv | 37 +++
 rtl/bp_me_dword_block_buffer.sv | 36 +++
 rtl/bp_me_cache_dma_to_block_mem.sv | 136 +++++++++++++
 tb/tb_bp_me_cache_dma_to_block_mem.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_me_pkg.sv
// Shared types for the memory-end DMA-to-block adapter: bedrock message
// types, the adapter FSM state encoding and header-width helpers.
package bp_me_pkg;

  localparam int bedrock_msg_type_width_gp = 4;
  localparam int bedrock_size_width_gp     = 3;

  typedef enum logic [bedrock_msg_type_width_gp-1:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3,
    e_bedrock_mem_pre   = 4'd4,
    e_bedrock_mem_amo   = 4'd5
  } bp_bedrock_mem_type_e;

  typedef enum logic [2:0] {
    e_ready,
    e_wr_collect,
    e_wr_issue,
    e_rd_issue,
    e_rd_wait,
    e_resp_hdr,
    e_rd_stream
  } bp_me_dma_blk_state_e;

  // Width of a dram-format header: {payload, size, addr, msg_type}
  function automatic int bp_me_hdr_width(input int paddr_w, input int payload_w);
    return payload_w + bedrock_size_width_gp + paddr_w + bedrock_msg_type_width_gp;
  endfunction

  // clog2 that never returns 0, so a 1-entry counter still has a bit
  function automatic int bp_me_safe_clog2(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/bp_me_dword_block_buffer.sv
// Block-wide register file addressed as dwords. Word 0 sits in the LSBs.
// Pure storage: the caller decides when to write, load or read.
module bp_me_dword_block_buffer
  import bp_me_pkg::*;
#(
  parameter int words_p       = 8,
  parameter int dword_width_p = 64,
  parameter int idx_width_p   = bp_me_safe_clog2(words_p)
) (
  input  logic                               clk_i,
  input  logic                               w_v_i,
  input  logic [idx_width_p-1:0]             w_idx_i,
  input  logic [dword_width_p-1:0]           w_data_i,
  input  logic                               ld_v_i,
  input  logic [words_p*dword_width_p-1:0]   ld_data_i,
  input  logic [idx_width_p-1:0]             r_idx_i,
  output logic [dword_width_p-1:0]           r_data_o,
  output logic [words_p*dword_width_p-1:0]   data_o
);

  logic [words_p-1:0][dword_width_p-1:0] mem_r;

  for (genvar i = 0; i < words_p; i++) begin : g_word
    // Full-block load wins over a single-word write; the two never overlap in use
    always_ff @(posedge clk_i) begin
      if (ld_v_i)
        mem_r[i] <= ld_data_i[i*dword_width_p +: dword_width_p];
      else if (w_v_i && (w_idx_i == idx_width_p'(i)))
        mem_r[i] <= w_data_i;
    end
  end

  assign r_data_o = mem_r[r_idx_i];
  assign data_o   = mem_r;

endmodule

// File: rtl/bp_me_cache_dma_to_block_mem.sv
// Adapts the L2 slice DMA port (header + dword beats) to a single-beat
// block-wide memory. One transaction in flight; one shared block buffer.
module bp_me_cache_dma_to_block_mem
  import bp_me_pkg::*;
#(
  parameter int paddr_width_p     = 40,
  parameter int dword_width_p     = 64,
  parameter int cce_block_width_p = 512,
  parameter int payload_width_p   = 16,
  parameter int hdr_width_p       = bp_me_hdr_width(paddr_width_p, payload_width_p)
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,

  input  logic [hdr_width_p-1:0]       mem_cmd_header_i,
  input  logic                         mem_cmd_header_v_i,
  output logic                         mem_cmd_header_yumi_o,
  input  logic [dword_width_p-1:0]     mem_cmd_data_i,
  input  logic                         mem_cmd_data_v_i,
  output logic                         mem_cmd_data_yumi_o,

  output logic [hdr_width_p-1:0]       mem_resp_header_o,
  output logic                         mem_resp_header_v_o,
  input  logic                         mem_resp_header_ready_i,
  output logic [dword_width_p-1:0]     mem_resp_data_o,
  output logic                         mem_resp_data_v_o,
  input  logic                         mem_resp_data_ready_i,

  output logic                         blk_v_o,
  output logic                         blk_w_o,
  output logic [paddr_width_p-1:0]     blk_addr_o,
  output logic [cce_block_width_p-1:0] blk_data_o,
  input  logic                         blk_ready_i,
  input  logic                         blk_data_v_i,
  input  logic [cce_block_width_p-1:0] blk_data_i,
  output logic                         blk_data_yumi_o
);

  localparam int words_lp        = cce_block_width_p / dword_width_p;
  localparam int cnt_width_lp    = bp_me_safe_clog2(words_lp);
  localparam int offset_width_lp = $clog2(cce_block_width_p / 8);

  typedef struct packed {
    logic [payload_width_p-1:0]           payload;
    logic [bedrock_size_width_gp-1:0]     size;
    logic [paddr_width_p-1:0]             addr;
    bp_bedrock_mem_type_e                 msg_type;
  } hdr_s;

  bp_me_dma_blk_state_e state_r, state_n;
  hdr_s                 hdr_r, hdr_aligned;
  logic [cnt_width_lp-1:0] cnt_r;

  logic hdr_accept, data_accept, blk_rd_yumi, resp_data_hs, cnt_last, is_wr;

  // Incoming header with the block offset stripped; size is ignored downstream
  always_comb begin
    hdr_aligned = hdr_s'(mem_cmd_header_i);
    hdr_aligned.addr[offset_width_lp-1:0] = '0;
  end

  // Yumis are gated by reset so nothing is consumed while reset is held
  assign hdr_accept   = reset_n_i & (state_r == e_ready)      & mem_cmd_header_v_i;
  assign data_accept  = reset_n_i & (state_r == e_wr_collect) & mem_cmd_data_v_i;
  assign blk_rd_yumi  = reset_n_i & (state_r == e_rd_wait)    & blk_data_v_i;
  assign resp_data_hs = mem_resp_data_v_o & mem_resp_data_ready_i;
  assign cnt_last     = (cnt_r == cnt_width_lp'(words_lp - 1));
  assign is_wr        = (hdr_r.msg_type == e_bedrock_mem_wr);

  assign mem_cmd_header_yumi_o = hdr_accept;
  assign mem_cmd_data_yumi_o   = data_accept;
  assign blk_data_yumi_o       = blk_rd_yumi;

  assign blk_v_o             = (state_r == e_wr_issue) | (state_r == e_rd_issue);
  assign blk_w_o             = (state_r == e_wr_issue);
  assign blk_addr_o          = hdr_r.addr;
  assign mem_resp_header_o   = hdr_r;
  assign mem_resp_header_v_o = (state_r == e_resp_hdr);
  assign mem_resp_data_v_o   = (state_r == e_rd_stream);

  // State, beat counter and latched header
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= e_ready;
      cnt_r   <= '0;
      hdr_r   <= '0;
    end else begin
      state_r <= state_n;
      if (hdr_accept)
        hdr_r <= hdr_aligned;
      if (data_accept | resp_data_hs)
        cnt_r <= cnt_last ? '0 : cnt_r + 1'b1;
    end
  end

  // Next-state: everything that is not a plain write is serviced as a read
  always_comb begin
    state_n = state_r;
    unique case (state_r)
      e_ready:
        if (hdr_accept)
          state_n = (hdr_aligned.msg_type == e_bedrock_mem_wr) ? e_wr_collect : e_rd_issue;
      e_wr_collect:
        if (data_accept && cnt_last) state_n = e_wr_issue;
      e_wr_issue:
        if (blk_ready_i) state_n = e_resp_hdr;
      e_rd_issue:
        if (blk_ready_i) state_n = e_rd_wait;
      e_rd_wait:
        if (blk_rd_yumi) state_n = e_resp_hdr;
      e_resp_hdr:
        if (mem_resp_header_ready_i) state_n = is_wr ? e_ready : e_rd_stream;
      e_rd_stream:
        if (resp_data_hs && cnt_last) state_n = e_ready;
      default:
        state_n = e_ready;
    endcase
  end

  bp_me_dword_block_buffer #(
    .words_p      (words_lp),
    .dword_width_p(dword_width_p),
    .idx_width_p  (cnt_width_lp)
  ) buffer (
    .clk_i    (clk_i),
    .w_v_i    (data_accept),
    .w_idx_i  (cnt_r),
    .w_data_i (mem_cmd_data_i),
    .ld_v_i   (blk_rd_yumi),
    .ld_data_i(blk_data_i),
    .r_idx_i  (cnt_r),
    .r_data_o (mem_resp_data_o),
    .data_o   (blk_data_o)
  );

endmodule

// File: tb/tb_bp_me_cache_dma_to_block_mem.sv
// Directed bench: a table of write/read transactions plus hand-written
// sequences for same-cycle header/data and mid-transaction reset.
module tb_bp_me_cache_dma_to_block_mem;
  import bp_me_pkg::*;

  localparam int PADDR = 40;
  localparam int DW    = 64;
  localparam int BW    = 512;
  localparam int PW    = 16;
  localparam int HW    = PW + 3 + PADDR + 4;
  localparam int WORDS = BW / DW;

  typedef struct packed {
    logic [PW-1:0]    payload;
    logic [2:0]       size;
    logic [PADDR-1:0] addr;
    logic [3:0]       msg_type;
  } hdr_t;

  typedef struct {
    bit               wr;
    logic [3:0]       mt;
    logic [PADDR-1:0] addr;
    logic [PW-1:0]    payload;
    logic [DW-1:0]    base;
    int               rdy_dly;
    int               dv_dly;
    bit               gaps;
    bit               same;
    logic [PADDR-1:0] exp_addr;
  } vec_t;

  logic clk, rst_n;
  logic [HW-1:0] cmd_hdr;
  logic cmd_hdr_v, cmd_hdr_yumi;
  logic [DW-1:0] cmd_data;
  logic cmd_data_v, cmd_data_yumi;
  logic [HW-1:0] resp_hdr;
  logic resp_hdr_v, resp_hdr_ready;
  logic [DW-1:0] resp_data;
  logic resp_data_v, resp_data_ready;
  logic blk_v, blk_w, blk_ready, blk_data_v, blk_data_yumi;
  logic [PADDR-1:0] blk_addr;
  logic [BW-1:0] blk_data_out, blk_data_in;

  int checks = 0;
  int errors = 0;

  bp_me_cache_dma_to_block_mem #(
    .paddr_width_p(PADDR), .dword_width_p(DW), .cce_block_width_p(BW), .payload_width_p(PW)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .mem_cmd_header_i(cmd_hdr), .mem_cmd_header_v_i(cmd_hdr_v), .mem_cmd_header_yumi_o(cmd_hdr_yumi),
    .mem_cmd_data_i(cmd_data), .mem_cmd_data_v_i(cmd_data_v), .mem_cmd_data_yumi_o(cmd_data_yumi),
    .mem_resp_header_o(resp_hdr), .mem_resp_header_v_o(resp_hdr_v), .mem_resp_header_ready_i(resp_hdr_ready),
    .mem_resp_data_o(resp_data), .mem_resp_data_v_o(resp_data_v), .mem_resp_data_ready_i(resp_data_ready),
    .blk_v_o(blk_v), .blk_w_o(blk_w), .blk_addr_o(blk_addr), .blk_data_o(blk_data_out),
    .blk_ready_i(blk_ready), .blk_data_v_i(blk_data_v), .blk_data_i(blk_data_in),
    .blk_data_yumi_o(blk_data_yumi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BW-1:0] pattern(input logic [DW-1:0] base);
    logic [BW-1:0] b;
    for (int i = 0; i < WORDS; i++) b[i*DW +: DW] = base + DW'(i);
    return b;
  endfunction

  function automatic logic [HW-1:0] mk_hdr(input vec_t v, input bit aligned);
    hdr_t h;
    h.payload  = v.payload;
    h.size     = 3'd6;
    h.addr     = aligned ? v.exp_addr : v.addr;
    h.msg_type = v.mt;
    return h;
  endfunction

  task automatic idle_inputs();
    cmd_hdr = '0; cmd_hdr_v = 0; cmd_data = '0; cmd_data_v = 0;
    resp_hdr_ready = 0; resp_data_ready = 0;
    blk_ready = 0; blk_data_v = 0; blk_data_in = '0;
  endtask

  // Header handshake; optionally present beat 0 in the same cycle
  task automatic send_header(input vec_t v);
    cmd_hdr = mk_hdr(v, 1'b0); cmd_hdr_v = 1;
    cmd_data = v.base; cmd_data_v = v.same;
    #1;
    chk("hdr_yumi", BW'(cmd_hdr_yumi), BW'(1));
    if (v.same) chk("same_cycle_no_data_yumi", BW'(cmd_data_yumi), BW'(0));
    step();
    cmd_hdr_v = 0; cmd_hdr = '0; cmd_data_v = 0;
  endtask

  task automatic push_beats(input logic [DW-1:0] base, input int n, input bit gaps, output int pushed);
    int bad = 0;
    int budget = 0;
    pushed = 0;
    while (pushed < n && budget < 400) begin
      cmd_data_v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      cmd_data   = base + DW'(pushed);
      #1;
      if (cmd_data_yumi !== cmd_data_v || blk_v !== 1'b0) bad++;
      if (cmd_data_v) pushed++;
      step();
      budget++;
    end
    cmd_data_v = 0;
    chk("wr_yumi_tracks_v", BW'(bad), BW'(0));
  endtask

  task automatic do_write(input vec_t v);
    int pushed, hold_bad;
    send_header(v);
    push_beats(v.base, WORDS, v.gaps, pushed);
    chk("wr_beats", BW'(pushed), BW'(WORDS));
    chk("wr_cnt_wrap", BW'(dut.cnt_r), BW'(0));
    #1;
    chk("wr_blk_v", BW'(blk_v), BW'(1));
    chk("wr_blk_w", BW'(blk_w), BW'(1));
    chk("wr_blk_addr", BW'(blk_addr), BW'(v.exp_addr));
    chk("wr_blk_data", blk_data_out, pattern(v.base));
    hold_bad = 0;
    repeat (v.rdy_dly) begin
      step();
      if (blk_v !== 1'b1 || blk_w !== 1'b1) hold_bad++;
    end
    chk("wr_blk_hold", BW'(hold_bad), BW'(0));
    blk_ready = 1;
    step();
    blk_ready = 0; resp_hdr_ready = 1;
    #1;
    chk("wr_resp_hdr_v", BW'(resp_hdr_v), BW'(1));
    chk("wr_resp_hdr", BW'(resp_hdr), BW'(mk_hdr(v, 1'b1)));
    step();
    resp_hdr_ready = 0;
    #1;
    chk("wr_no_resp_data", BW'({resp_data_v, resp_hdr_v, blk_v}), BW'(0));
  endtask

  task automatic do_read(input vec_t v);
    int hold_bad, got, budget, bad;
    send_header(v);
    #1;
    chk("rd_blk_v", BW'(blk_v), BW'(1));
    chk("rd_blk_w", BW'(blk_w), BW'(0));
    chk("rd_blk_addr", BW'(blk_addr), BW'(v.exp_addr));
    hold_bad = 0;
    repeat (v.rdy_dly) begin
      step();
      if (blk_v !== 1'b1 || blk_data_yumi !== 1'b0) hold_bad++;
    end
    blk_ready = 1;
    step();
    blk_ready = 0;
    repeat (v.dv_dly) begin
      #1;
      if (blk_data_yumi !== 1'b0 || blk_v !== 1'b0) hold_bad++;
      step();
    end
    chk("rd_wait_hold", BW'(hold_bad), BW'(0));
    blk_data_v = 1; blk_data_in = pattern(v.base);
    #1;
    chk("rd_blk_yumi", BW'(blk_data_yumi), BW'(1));
    step();
    blk_data_v = 0; blk_data_in = '1;
    resp_hdr_ready = 1;
    #1;
    chk("rd_resp_hdr_v", BW'(resp_hdr_v), BW'(1));
    chk("rd_resp_hdr", BW'(resp_hdr), BW'(mk_hdr(v, 1'b1)));
    step();
    resp_hdr_ready = 0;
    got = 0; budget = 0; bad = 0;
    while (got < WORDS && budget < 400) begin
      resp_data_ready = v.gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (resp_data_v !== 1'b1) bad++;
      if (resp_data_ready) begin
        chk("rd_beat", BW'(resp_data), BW'(v.base + DW'(got)));
        got++;
      end
      step();
      budget++;
    end
    resp_data_ready = 0;
    chk("rd_stream_valid", BW'(bad), BW'(0));
    chk("rd_beats", BW'(got), BW'(WORDS));
    #1;
    chk("rd_no_extra_beat", BW'(resp_data_v), BW'(0));
    chk("rd_cnt_wrap", BW'(dut.cnt_r), BW'(0));
  endtask

  vec_t vecs[6];
  vec_t rv;
  int pushed;

  initial begin
    vecs[0] = '{1, 4'(e_bedrock_mem_wr),    40'h00_8000_0047, 16'h1111, 64'h0,   0, 0, 0, 0, 40'h00_8000_0040};
    vecs[1] = '{0, 4'(e_bedrock_mem_rd),    40'h00_1234_5678, 16'h2222, 64'hA0,  3, 5, 0, 0, 40'h00_1234_5640};
    vecs[2] = '{1, 4'(e_bedrock_mem_wr),    40'h00_FFFF_FFFF, 16'h3333, 64'h100, 2, 0, 1, 0, 40'h00_FFFF_FFC0};
    vecs[3] = '{0, 4'(e_bedrock_mem_rd),    40'hFF_FFFF_FFFF, 16'h4444, 64'h200, 0, 0, 1, 0, 40'hFF_FFFF_FFC0};
    vecs[4] = '{0, 4'(e_bedrock_mem_uc_rd), 40'h00_0000_0040, 16'h5555, 64'h300, 1, 2, 0, 0, 40'h00_0000_0040};
    vecs[5] = '{1, 4'(e_bedrock_mem_wr),    40'h00_0000_007F, 16'h6666, 64'h400, 0, 0, 0, 1, 40'h00_0000_0040};

    idle_inputs();
    rst_n = 0;
    #3;
    cmd_hdr_v = 1; cmd_data_v = 1; blk_data_v = 1;
    #1;
    chk("reset_yumis", BW'({cmd_hdr_yumi, cmd_data_yumi, blk_data_yumi}), BW'(0));
    chk("reset_valids", BW'({blk_v, resp_hdr_v, resp_data_v}), BW'(0));
    chk("reset_resp_hdr", BW'(resp_hdr), BW'(0));
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1;
    step();

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].wr) do_write(vecs[i]);
      else            do_read(vecs[i]);
    end

    // Reset in the middle of collecting beats: partial block is discarded
    rv = '{1, 4'(e_bedrock_mem_wr), 40'h00_0000_1234, 16'h7777, 64'h500, 0, 0, 0, 0, 40'h00_0000_1200};
    send_header(rv);
    push_beats(rv.base, 4, 1'b0, pushed);
    cmd_hdr_v = 1; cmd_data_v = 1; blk_data_v = 1;
    #2;
    rst_n = 0;
    #1;
    chk("midreset_yumis", BW'({cmd_hdr_yumi, cmd_data_yumi, blk_data_yumi}), BW'(0));
    chk("midreset_valids", BW'({blk_v, resp_hdr_v, resp_data_v}), BW'(0));
    chk("midreset_cnt", BW'(dut.cnt_r), BW'(0));
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1;
    step();
    rv.base = 64'h600;
    do_write(rv);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so a stuck handshake cannot hang the run
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "timeout");
  end

endmodule
